// File: rtl/user_project_io_bridge.sv
// rtl/user_project_io_bridge.sv - per-channel bypass/registered/synchronised/debounced IO bridge
module user_project_io_bridge #(
  parameter int NUM_CH   = 16,
  parameter int DEBOUNCE = 4,
  localparam int CNT_W   = $clog2(DEBOUNCE + 1)
) (
  input  logic                  UserCLK,
  input  logic                  UserRST,
  input  logic [2*NUM_CH-1:0]   ConfigBits,
  input  logic [NUM_CH-1:0]     UIN,
  output logic [NUM_CH-1:0]     UOUT,
  output logic [NUM_CH-1:0]     UOE,
  input  logic [NUM_CH-1:0]     FIN,
  input  logic [NUM_CH-1:0]     FOE,
  output logic [NUM_CH-1:0]     FOUT
);

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_REG    = 2'd1;
  localparam logic [1:0] MODE_SYNC   = 2'd2;
  localparam logic [1:0] MODE_DEB    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode;
    logic             r1;
    logic             s1;
    logic             s2;
    logic             d;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             oe_q;
    logic             fout_c;
    logic             uout_c;
    logic             uoe_c;

    assign mode = ConfigBits[2*i +: 2];

    // Inbound capture flops run in every mode so a mode switch sees live data.
    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        r1 <= 1'b0;
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        r1 <= UIN[i];
        s1 <= UIN[i];
        s2 <= s1;
      end
    end

    // Debounce: d only moves after s2 disagrees for DEBOUNCE cycles; outside
    // debounce mode d shadows s2 so entering the mode never glitches.
    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        d   <= 1'b0;
        cnt <= '0;
      end else if (mode != MODE_DEB) begin
        d   <= s2;
        cnt <= '0;
      end else if (s2 == d) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        d   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end

    // Outbound data and enable share one register stage to stay aligned.
    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        out_q <= 1'b0;
        oe_q  <= 1'b0;
      end else begin
        out_q <= FIN[i];
        oe_q  <= FOE[i];
      end
    end

    // Mode selects which source drives each output; bypass stays combinational.
    always_comb begin
      fout_c = UIN[i];
      uout_c = FIN[i];
      uoe_c  = FOE[i];
      case (mode)
        MODE_REG:  fout_c = r1;
        MODE_SYNC: fout_c = s2;
        MODE_DEB:  fout_c = d;
        default:   fout_c = UIN[i];
      endcase
      if (mode != MODE_BYPASS) begin
        uout_c = out_q;
        uoe_c  = oe_q;
      end
    end

    assign FOUT[i] = fout_c;
    assign UOUT[i] = uout_c;
    assign UOE[i]  = uoe_c;
  end

endmodule

// File: tb/tb_user_project_io_bridge.sv
// tb/tb_user_project_io_bridge.sv - self-checking bench for user_project_io_bridge
module tb_user_project_io_bridge;
  localparam int N   = 16;
  localparam int DEB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*N-1:0] cfg;
  logic [N-1:0]   uin, fin, foe;
  logic [N-1:0]   uout, uoe, fout;
  logic           cmp_en = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  user_project_io_bridge #(.NUM_CH(N), .DEBOUNCE(DEB)) dut (
    .UserCLK(clk), .UserRST(rst), .ConfigBits(cfg),
    .UIN(uin), .UOUT(uout), .UOE(uoe),
    .FIN(fin), .FOE(foe), .FOUT(fout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: UIN history as seen at past edges, debounce level and disagreement run.
  logic [N-1:0] h0 = '0, h1 = '0, dm = '0, fq = '0, eq = '0;
  int run [N];

  function automatic logic [1:0] mode_of(input int ch);
    return cfg[2*ch +: 2];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h0 = '0; h1 = '0; dm = '0; fq = '0; eq = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mode_of(i) == 2'd3) begin
          run[i] = (h1[i] != dm[i]) ? run[i] + 1 : 0;
          if (run[i] == DEB) begin
            dm[i]  = h1[i];
            run[i] = 0;
          end
        end else begin
          dm[i]  = h1[i];
          run[i] = 0;
        end
      end
      h1 = h0; h0 = uin; fq = fin; eq = foe;
    end
  end

  function automatic logic [N-1:0] exp_fout();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      case (mode_of(i))
        2'd0: r[i] = uin[i];
        2'd1: r[i] = h0[i];
        2'd2: r[i] = h1[i];
        default: r[i] = dm[i];
      endcase
    return r;
  endfunction

  function automatic logic [N-1:0] exp_uout();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mode_of(i) == 2'd0) ? fin[i] : fq[i];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_uoe();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mode_of(i) == 2'd0) ? foe[i] : eq[i];
    return r;
  endfunction

  // Every cycle: compare DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_fout", 32'(fout), 32'(exp_fout()));
      chk("model_uout", 32'(uout), 32'(exp_uout()));
      chk("model_uoe",  32'(uoe),  32'(exp_uoe()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    cfg[2*ch +: 2] = m;
  endtask

  initial begin
    int first, hi;
    rst = 1'b1; cfg = {N{2'b01}}; uin = '1; fin = '1; foe = '1;
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    chk("rst_fout", 32'(fout), 32'h0);
    chk("rst_uout", 32'(uout), 32'h0);
    chk("rst_uoe",  32'(uoe),  32'h0);
    rst = 1'b0;
    tick(1);
    chk("rel_fout", 32'(fout), 32'hffff);
    chk("rel_uout", 32'(uout), 32'hffff);
    chk("rel_uoe",  32'(uoe),  32'hffff);

    set_mode(0, 2'd0); set_mode(1, 2'd1); set_mode(2, 2'd2); set_mode(3, 2'd3);
    uin = '0; fin = '0; foe = '0;
    tick(10);

    // Bypass follows inputs between edges and ignores reset.
    uin[0] = 1'b1; #1 chk("byp_fout_hi", 32'(fout[0]), 32'd1);
    fin[0] = 1'b1; #1 chk("byp_uout_hi", 32'(uout[0]), 32'd1);
    tick(1);
    foe[0] = 1'b1; #1 chk("byp_uoe_hi", 32'(uoe[0]), 32'd1);
    uin[0] = 1'b0; #1 chk("byp_fout_lo", 32'(fout[0]), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("byp_rst_uout", 32'(uout[0]), 32'd1);
    uin[0] = 1'b1; #1 chk("byp_rst_fout", 32'(fout[0]), 32'd1);
    rst = 1'b0; uin[0] = 1'b0; fin[0] = 1'b0; foe[0] = 1'b0;
    tick(10);

    // Latency per mode: 1, 2 and 2+DEB cycles.
    uin[3:1] = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("lat_m1", 32'(fout[1]), 32'd1);
      chk("lat_m2", 32'(fout[2]), 32'(k >= 2));
      chk("lat_m3", 32'(fout[3]), 32'(k >= 2 + DEB));
    end
    uin[3:1] = '0;
    tick(10);

    // Short pulses are rejected by the debouncer.
    for (int w = 1; w <= 3; w++) begin
      uin[3] = 1'b1;
      repeat (w) begin tick(1); chk("deb_reject", 32'(fout[3]), 32'd0); end
      uin[3] = 1'b0;
      repeat (5) begin tick(1); chk("deb_reject", 32'(fout[3]), 32'd0); end
    end

    // A 6-cycle pulse passes intact, delayed by 2+DEB.
    first = -1; hi = 0;
    uin[3] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (fout[3]) begin
        hi++;
        if (first < 0) first = k;
      end
      if (k == 6) uin[3] = 1'b0;
    end
    chk("deb_accept_start", 32'(first), 32'd6);
    chk("deb_accept_width", 32'(hi), 32'd6);

    // Output enable on a registered channel.
    fin[5] = 1'b1; foe[5] = 1'b1;
    #1 chk("oe_not_yet", 32'(uoe[5]), 32'd0);
    tick(1);
    chk("oe_on",   32'(uoe[5]),  32'd1);
    chk("oe_data", 32'(uout[5]), 32'd1);
    tick(4);
    foe[5] = 1'b0;
    #1 chk("oe_hold", 32'(uoe[5]), 32'd1);
    tick(1);
    chk("oe_off",      32'(uoe[5]),  32'd0);
    chk("oe_data_hld", 32'(uout[5]), 32'd1);

    // Reset mid-debounce discards the partial count.
    uin[3] = 1'b1;
    tick(5);
    chk("mid_pre_rst", 32'(fout[3]), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("mid_rst_restart", 32'(fout[3]), 32'(k == 6));
    end

    // Mode 3 -> 2 -> 3 mid-count: d picks up s2 while away, count restarts.
    uin[3] = 1'b0;
    tick(10);
    uin[3] = 1'b1;
    tick(5);
    chk("rcf_pre", 32'(fout[3]), 32'd0);
    set_mode(3, 2'd2);
    #1 chk("rcf_m2", 32'(fout[3]), 32'd1);
    tick(1);
    set_mode(3, 2'd3);
    #1 chk("rcf_m3", 32'(fout[3]), 32'd1);
    uin[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("rcf_fresh", 32'(fout[3]), 32'(k < 6));
    end

    tick(3);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/user_project_io_bridge.md
Name: user_project_io_bridge

Overview:
- Parametrised successor to the single-tile user-project IO pass-through in the N-terminal tile.
- Bridges NUM_CH bidirectional channels between the external user project (UIN/UOUT/UOE) and the fabric (FIN/FOUT/FOE).
- Per-channel 2-bit configuration selects one of four modes: combinational bypass, registered, 2-FF synchronised, or synchronised plus debounced.
- Adds an output-enable path.
- Configuration comes from fabric config bits. The block is static during normal use but must tolerate reconfiguration while running.

Parameters:
- NUM_CH, 16, number of IO channels.
- DEBOUNCE, 4, consecutive stable cycles required in mode 3; legal range 1..255.
- CNT_W, $clog2(DEBOUNCE+1), debounce counter width (derived, not overridden).

Ports:
- UserCLK  input  1  fabric user clock; all flops rise-edge.
- UserRST  input  1  synchronous active-high reset.
- ConfigBits  input  2*NUM_CH  mode for channel i = ConfigBits[2i+1:2i]. (* FABulous, CONFIG *)
- UIN  input  NUM_CH  from user project. (* FABulous, EXTERNAL *)
- UOUT  output  NUM_CH  to user project. (* FABulous, EXTERNAL *)
- UOE  output  NUM_CH  output enable to user project, 1 = drive. (* FABulous, EXTERNAL *)
- FIN  input  NUM_CH  data from fabric.
- FOE  input  NUM_CH  output-enable request from fabric.
- FOUT  output  NUM_CH  data to fabric.

Behaviour:
Modes, per channel i:
- 0 = bypass.
- 1 = registered.
- 2 = synchronised.
- 3 = debounced.

Inbound path, UIN -> FOUT:
- Mode 0: FOUT[i] = UIN[i], combinational, 0 latency.
- Mode 1: single flop r1; FOUT valid 1 cycle after UIN.
- Mode 2: two-flop synchroniser s1 -> s2; FOUT = s2; latency 2.
- Mode 3: s2 feeds a debounce stage.
  - Registered state d[i] and counter cnt[i].
  - Each cycle: if s2 == d, cnt <= 0.
  - Else if cnt == DEBOUNCE-1: d <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - FOUT = d.
  - Latency from a clean UIN edge to FOUT = 2 + DEBOUNCE cycles.
  - A glitch shorter than DEBOUNCE cycles at s2 never reaches FOUT.

Outbound path, FIN/FOE -> UOUT/UOE:
- Mode 0: combinational.
- Modes 1-3: one flop each, latency 1. Data and enable are registered together so they stay aligned.

Clocking and reset:
- All flops (r1, s1, s2, d, cnt, outbound regs) clock every cycle regardless of mode. The mode only selects which value drives the output.
- cnt is forced to 0 whenever mode != 3.
- UserRST = 1 at a rising edge clears every flop to 0.
- Effect of reset in modes 1-3: FOUT = 0, UOUT = 0, UOE = 0 (outputs undriven), cnt = 0.
- Mode 0 outputs stay combinational and are unaffected by reset.
- Reset mid-debounce discards the partial count. After release, the channel restarts from d = 0.

Reconfiguration:
- A ConfigBits change takes effect on the output mux immediately.
- Switching into mode 1/2/3 presents the already-running flop contents, with no extra settle cycle beyond normal latency.
- Switching into mode 3 starts with cnt = 0. d holds its last value: it keeps tracking as if in mode 3 only while mode == 3; otherwise d <= s2 each cycle, so entry is glitch-free.

Channels are fully independent; there is no cross-channel coupling.

Width rules:
- cnt saturates by construction: it never exceeds DEBOUNCE-1.
- DEBOUNCE = 1 means d follows s2 with 1 extra cycle.

Test Plan:
- Reset and defaults: ConfigBits = all 2'b01, UserRST held 3 cycles with FIN = FOE = UIN = all 1s -> during reset UOUT = UOE = FOUT = 0; first edge after release -> all 1s.
- Bypass: ch0 mode 0, toggle UIN[0] and FIN[0] between edges -> FOUT[0]/UOUT[0] follow in the same delta with no clock dependency; asserting UserRST does not change them.
- Latency per mode: ch1 mode 1, ch2 mode 2, ch3 mode 3, DEBOUNCE = 4, step UIN[3:1] 0 -> 1 at cycle 10 -> FOUT[1] rises at cycle 11, FOUT[2] at 12, FOUT[3] at 16.
- Debounce reject and accept: ch3 mode 3, UIN[3] high pulses of 1, 2 and 3 cycles separated by 5 low cycles -> FOUT[3] stays 0. Then a 6-cycle high pulse -> FOUT[3] high for exactly 6 cycles, starting 6 cycles after the rising edge.
- Output enable: ch5 mode 1, FOE[5] = 1 and FIN[5] = 1 at cycle 20 -> UOE[5] = UOUT[5] = 1 at cycle 21. FOE[5] = 0 at cycle 25 -> UOE[5] = 0 at cycle 26.
- Mid-operation: ch3 mode 3 with a debounce count at 3, then either assert UserRST, or switch ch3 to mode 2 and back -> cnt = 0, FOUT[3] shows no spurious pulse, and a fresh 4-cycle stable input is required to toggle.
